svm_classifier: RTL and testbench

Downstream consumer of the deskew stage in the digit-recognition accelerator. Once deskew has written the 28x28 corrected image to BRAM words 784..1567, this block reads it, evaluates a cubic polynomial-kernel SVM against each class's support vectors, and reports the index of the highest-scoring class. It shares the start/ready control style and the 1-cycle-latency BRAM read protocol used by deskew.

---
 rtl/svm_classifier_if.sv | 30 +++
 rtl/svm_classifier.sv | 168 ++++++++++++++++
 tb/tb_svm_classifier.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/svm_classifier_if.sv
// Control and memory-read bundle between the SVM classifier and its image, SV and coefficient stores.
// The classifier side uses the slave modport; the controller/memory side uses master.
interface svm_classifier_if #(
   parameter int WIDTH = 16,
   parameter int SV_AW = 18,
   parameter int CF_AW = 8
);
   logic                    start;
   logic                    ready;
   logic [3:0]              result;
   logic [10:0]             img_address;
   logic                    img_en;
   logic signed [WIDTH-1:0] img_in_data;
   logic [SV_AW-1:0]        sv_address;
   logic                    sv_en;
   logic signed [WIDTH-1:0] sv_in_data;
   logic [CF_AW-1:0]        coef_address;
   logic                    coef_en;
   logic signed [WIDTH-1:0] coef_in_data;

   modport slave (
      input  start, img_in_data, sv_in_data, coef_in_data,
      output ready, result, img_address, img_en, sv_address, sv_en, coef_address, coef_en
   );

   modport master (
      output start, img_in_data, sv_in_data, coef_in_data,
      input  ready, result, img_address, img_en, sv_address, sv_en, coef_address, coef_en
   );
endinterface

// File: rtl/svm_classifier.sv
// Cubic polynomial-kernel SVM over the deskewed 28x28 image (BRAM words 784..1567).
// Streams each support vector against the image, scores every class and reports the argmax.
module svm_classifier #(
   parameter int WIDTH        = 16,
   parameter int NUM_CLASSES  = 10,
   parameter int SV_PER_CLASS = 16,
   parameter int SV_AW        = 18,
   parameter int CF_AW        = 8
) (
   input logic            clk,
   input logic            reset,
   svm_classifier_if.slave bus
);
   localparam int SW = (SV_PER_CLASS > 1) ? $clog2(SV_PER_CLASS) : 1;
   localparam logic [9:0]       PIX_LAST = 10'd783;
   localparam logic [SW-1:0]    SV_LAST  = SW'(SV_PER_CLASS - 1);
   localparam logic [3:0]       CLS_LAST = 4'(NUM_CLASSES - 1);
   localparam logic [SV_AW-1:0] SV_STEP  = SV_AW'(784);
   localparam logic [CF_AW-1:0] CF_STEP  = CF_AW'(SV_PER_CLASS + 1);
   localparam logic [CF_AW-1:0] CF_BIAS  = CF_AW'(SV_PER_CLASS);

   typedef enum logic [2:0] {
      ST_IDLE, ST_DOT, ST_DOT_LAST, ST_K1, ST_K2, ST_LMB, ST_BIAS_RD, ST_BIAS_ADD
   } state_t;

   function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
      if (v > 64'sd2147483647)       return 32'sh7FFFFFFF;
      else if (v < -64'sd2147483648) return 32'sh80000000;
      else                           return v[31:0];
   endfunction

   state_t                  r_state, w_next;
   logic [9:0]              r_pix;
   logic [SW-1:0]           r_sv;
   logic [3:0]              r_cls;
   logic [SV_AW-1:0]        r_sv_base;
   logic [CF_AW-1:0]        r_cf_base;
   logic signed [47:0]      r_dot, r_score, r_best;
   logic signed [31:0]      r_t, r_sq, r_k;
   logic signed [WIDTH-1:0] r_lmb;
   logic [3:0]              r_best_idx, r_result;

   logic signed [47:0] w_prod, w_lk, w_score_fin;
   logic signed [31:0] w_t, w_sq, w_k;
   logic signed [63:0] w_tt, w_kt;
   logic               w_take;

   // Kernel arithmetic: K1 forms t and t^2, K2 forms t^3, LMB weights by lambda.
   assign w_prod      = 48'(bus.img_in_data) * 48'(bus.sv_in_data);
   assign w_t         = sat32(64'(r_dot >>> 14)) + 32'sd16384;
   assign w_tt        = 64'(w_t) * 64'(w_t);
   assign w_sq        = sat32(w_tt >>> 14);
   assign w_kt        = 64'(r_sq) * 64'(r_t);
   assign w_k         = sat32(w_kt >>> 14);
   assign w_lk        = 48'(r_lmb) * 48'(r_k);
   assign w_score_fin = r_score + 48'(bus.coef_in_data);
   assign w_take      = (r_cls == 4'd0) || (w_score_fin > r_best);
   assign bus.result  = r_result;

   always_comb begin
      w_next           = r_state;
      bus.ready        = 1'b0;
      bus.img_en       = 1'b0;
      bus.img_address  = '0;
      bus.sv_en        = 1'b0;
      bus.sv_address   = '0;
      bus.coef_en      = 1'b0;
      bus.coef_address = '0;
      case (r_state)
         ST_IDLE: begin
            bus.ready = 1'b1;
            if (bus.start) w_next = ST_DOT;
         end
         ST_DOT: begin
            bus.img_en      = 1'b1;
            bus.img_address = 11'd784 + 11'(r_pix);
            bus.sv_en       = 1'b1;
            bus.sv_address  = r_sv_base + SV_AW'(r_pix);
            if (r_pix == PIX_LAST) w_next = ST_DOT_LAST;
         end
         ST_DOT_LAST: w_next = ST_K1;
         ST_K1: begin
            bus.coef_en      = 1'b1;
            bus.coef_address = r_cf_base + CF_AW'(r_sv);
            w_next           = ST_K2;
         end
         ST_K2:  w_next = ST_LMB;
         ST_LMB: w_next = (r_sv == SV_LAST) ? ST_BIAS_RD : ST_DOT;
         ST_BIAS_RD: begin
            bus.coef_en      = 1'b1;
            bus.coef_address = r_cf_base + CF_BIAS;
            w_next           = ST_BIAS_ADD;
         end
         ST_BIAS_ADD: w_next = (r_cls == CLS_LAST) ? ST_IDLE : ST_DOT;
         default:     w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_pix      <= '0;
         r_sv       <= '0;
         r_cls      <= '0;
         r_sv_base  <= '0;
         r_cf_base  <= '0;
         r_dot      <= '0;
         r_score    <= '0;
         r_best     <= '0;
         r_t        <= '0;
         r_sq       <= '0;
         r_k        <= '0;
         r_lmb      <= '0;
         r_best_idx <= '0;
         r_result   <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: if (bus.start) begin
               r_pix      <= '0;
               r_sv       <= '0;
               r_cls      <= '0;
               r_sv_base  <= '0;
               r_cf_base  <= '0;
               r_dot      <= '0;
               r_score    <= '0;
               r_best     <= '0;
               r_best_idx <= '0;
            end
            // Read data lags the address by one cycle, so pixel 0 carries nothing yet.
            ST_DOT: begin
               r_pix <= (r_pix == PIX_LAST) ? 10'd0 : r_pix + 10'd1;
               if (r_pix != 10'd0) r_dot <= r_dot + w_prod;
            end
            ST_DOT_LAST: r_dot <= r_dot + w_prod;
            ST_K1: begin
               r_t  <= w_t;
               r_sq <= w_sq;
            end
            ST_K2: begin
               r_k   <= w_k;
               r_lmb <= bus.coef_in_data;
            end
            ST_LMB: begin
               r_score   <= r_score + (w_lk >>> 14);
               r_dot     <= '0;
               r_sv_base <= r_sv_base + SV_STEP;
               if (r_sv != SV_LAST) r_sv <= r_sv + 1'b1;
            end
            ST_BIAS_ADD: begin
               r_score <= '0;
               if (w_take) begin
                  r_best     <= w_score_fin;
                  r_best_idx <= r_cls;
               end
               if (r_cls == CLS_LAST) begin
                  r_result <= w_take ? r_cls : r_best_idx;
               end else begin
                  r_cls     <= r_cls + 4'd1;
                  r_sv      <= '0;
                  r_cf_base <= r_cf_base + CF_STEP;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_svm_classifier.sv
// Bench for svm_classifier: directed vectors on a 2-class/1-SV instance, random golden-model
// runs on that instance and on a 3-class/2-SV instance.
module tb_svm_classifier;
   localparam int A_NC = 2, A_SPC = 1, B_NC = 3, B_SPC = 2;

   logic clk, reset;
   int   n_chk = 0, n_err = 0;

   svm_classifier_if #(.WIDTH(16), .SV_AW(18), .CF_AW(8)) ifa ();
   svm_classifier_if #(.WIDTH(16), .SV_AW(18), .CF_AW(8)) ifb ();

   svm_classifier #(.WIDTH(16), .NUM_CLASSES(A_NC), .SV_PER_CLASS(A_SPC), .SV_AW(18), .CF_AW(8))
      dut_a (.clk(clk), .reset(reset), .bus(ifa));
   svm_classifier #(.WIDTH(16), .NUM_CLASSES(B_NC), .SV_PER_CLASS(B_SPC), .SV_AW(18), .CF_AW(8))
      dut_b (.clk(clk), .reset(reset), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic signed [15:0] img_mem  [0:2047];
   logic signed [15:0] sv_mem   [0:8191];
   logic signed [15:0] coef_mem [0:255];

   // Synchronous-read memories with one cycle of latency
   always @(posedge clk) begin
      if (ifa.img_en)  ifa.img_in_data  <= img_mem[ifa.img_address];
      if (ifa.sv_en)   ifa.sv_in_data   <= sv_mem[ifa.sv_address[12:0]];
      if (ifa.coef_en) ifa.coef_in_data <= coef_mem[ifa.coef_address];
      if (ifb.img_en)  ifb.img_in_data  <= img_mem[ifb.img_address];
      if (ifb.sv_en)   ifb.sv_in_data   <= sv_mem[ifb.sv_address[12:0]];
      if (ifb.coef_en) ifb.coef_in_data <= coef_mem[ifb.coef_address];
   end

   // Final class scores, captured in the cycle after each bias read
   logic   a_pend = 1'b0, b_pend = 1'b0;
   int     a_cls = 0, b_cls = 0, seen_a = 0, seen_b = 0;
   longint cap_a [0:9];
   longint cap_b [0:9];
   always @(posedge clk) begin
      a_pend <= ifa.coef_en && ((int'(ifa.coef_address) % (A_SPC + 1)) == A_SPC);
      a_cls  <= (int'(ifa.coef_address) / (A_SPC + 1)) % 10;
      b_pend <= ifb.coef_en && ((int'(ifb.coef_address) % (B_SPC + 1)) == B_SPC);
      b_cls  <= (int'(ifb.coef_address) / (B_SPC + 1)) % 10;
   end
   always @(negedge clk) begin
      if (a_pend) begin
         cap_a[a_cls] <= longint'(dut_a.w_score_fin);
         seen_a       <= seen_a + 1;
      end
      if (b_pend) begin
         cap_b[b_cls] <= longint'(dut_b.w_score_fin);
         seen_b       <= seen_b + 1;
      end
   end

   // Address-sequence monitor on the small instance
   logic mon_en = 1'b0;
   int   img_cnt = 0, img_bad = 0, sv_cnt = 0, sv_bad = 0, cf_cnt = 0;
   int   cf_log [0:7];
   always @(posedge clk) if (mon_en) begin
      if (ifa.img_en) begin
         if (int'(ifa.img_address) != 784 + (img_cnt % 784)) img_bad <= img_bad + 1;
         img_cnt <= img_cnt + 1;
      end
      if (ifa.sv_en) begin
         if (int'(ifa.sv_address) != sv_cnt) sv_bad <= sv_bad + 1;
         sv_cnt <= sv_cnt + 1;
      end
      if (ifa.coef_en) begin
         if (cf_cnt < 8) cf_log[cf_cnt] <= int'(ifa.coef_address);
         cf_cnt <= cf_cnt + 1;
      end
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   function automatic logic rdy(input bit use_b);
      return use_b ? ifb.ready : ifa.ready;
   endfunction

   task automatic set_start(input bit use_b, input logic v);
      if (use_b) ifb.start = v;
      else       ifa.start = v;
   endtask

   // ---------------- reference model ----------------
   longint exp_sc [0:9];
   int     exp_win;

   function automatic longint sat32f(input longint v);
      if (v > 64'sd2147483647)  return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   task automatic ref_model(input int nc, input int spc);
      longint dot, t, sq, k, score, best;
      best = 0;
      exp_win = 0;
      for (int c = 0; c < nc; c++) begin
         score = 0;
         for (int s = 0; s < spc; s++) begin
            dot = 0;
            for (int i = 0; i < 784; i++)
               dot += longint'(img_mem[784 + i]) * longint'(sv_mem[(c * spc + s) * 784 + i]);
            t  = sat32f(dot >>> 14) + 16384;
            t  = longint'(int'(t));
            sq = sat32f((t * t) >>> 14);
            k  = sat32f((sq * t) >>> 14);
            score += (longint'(coef_mem[c * (spc + 1) + s]) * k) >>> 14;
         end
         score += longint'(coef_mem[c * (spc + 1) + spc]);
         exp_sc[c] = score;
         if (c == 0 || score > best) begin
            best    = score;
            exp_win = c;
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic clear_mems();
      foreach (img_mem[i])  img_mem[i]  = '0;
      foreach (sv_mem[i])   sv_mem[i]   = '0;
      foreach (coef_mem[i]) coef_mem[i] = '0;
   endtask

   // Per-SV mode mixes small, saturating-positive, saturating-negative and full-range vectors.
   task automatic fill_random(input int r);
      int m;
      logic signed [15:0] x;
      clear_mems();
      for (int i = 0; i < 784; i++) img_mem[784 + i] = 16'($urandom);
      for (int n = 0; n < 6; n++) begin
         m = (n + r) % 4;
         for (int i = 0; i < 784; i++) begin
            x = img_mem[784 + i];
            case (m)
               0:       sv_mem[n * 784 + i] = 16'($urandom_range(0, 2047)) - 16'd1024;
               1:       sv_mem[n * 784 + i] = x[15] ? 16'sh8000 : 16'sh7FFF;
               2:       sv_mem[n * 784 + i] = x[15] ? 16'sh7FFF : 16'sh8000;
               default: sv_mem[n * 784 + i] = 16'($urandom);
            endcase
         end
      end
      for (int k = 0; k < 9; k++) coef_mem[k] = 16'($urandom);
   endtask

   task automatic do_run(input bit use_b, input bit pulses, output int busy);
      int cyc;
      @(negedge clk); set_start(use_b, 1'b1);
      @(negedge clk); set_start(use_b, 1'b0);
      cyc = 1;
      while (rdy(use_b) !== 1'b1 && cyc < 10000) begin
         @(negedge clk);
         cyc++;
         set_start(use_b, pulses && (cyc == 100 || cyc == 900 || cyc == 1580));
      end
      set_start(use_b, 1'b0);
      busy = cyc - 1;
   endtask

   task automatic run_and_check(input bit use_b, input bit pulses, input string tag);
      int busy, seen0, nc, spc;
      nc    = use_b ? B_NC : A_NC;
      spc   = use_b ? B_SPC : A_SPC;
      seen0 = use_b ? seen_b : seen_a;
      do_run(use_b, pulses, busy);
      chk({tag, "_busy"}, busy, nc * (spc * 788 + 2));
      chk({tag, "_result"}, use_b ? ifb.result : ifa.result, exp_win);
      chk({tag, "_nscores"}, (use_b ? seen_b : seen_a) - seen0, nc);
      for (int c = 0; c < nc; c++)
         chk($sformatf("%s_score%0d", tag, c), use_b ? cap_b[c] : cap_a[c], exp_sc[c]);
   endtask

   task automatic check_idle(input bit use_b, input string tag);
      chk({tag, "_ready"},  use_b ? ifb.ready : ifa.ready, 1);
      chk({tag, "_result"}, use_b ? ifb.result : ifa.result, 0);
      chk({tag, "_img_en"}, use_b ? ifb.img_en : ifa.img_en, 0);
      chk({tag, "_sv_en"},  use_b ? ifb.sv_en : ifa.sv_en, 0);
      chk({tag, "_cf_en"},  use_b ? ifb.coef_en : ifa.coef_en, 0);
      chk({tag, "_img_ad"}, use_b ? ifb.img_address : ifa.img_address, 0);
      chk({tag, "_sv_ad"},  use_b ? ifb.sv_address : ifa.sv_address, 0);
      chk({tag, "_cf_ad"},  use_b ? ifb.coef_address : ifa.coef_address, 0);
   endtask

   typedef struct {
      logic signed [15:0] l0, b0, l1, b1, px, sv;
      int                 win;
      longint             s0, s1;
   } vec_t;
   vec_t vt [0:2];

   task automatic load_vec(input vec_t v);
      clear_mems();
      img_mem[784] = v.px;
      sv_mem[0]    = v.sv;
      coef_mem[0]  = v.l0;
      coef_mem[1]  = v.b0;
      coef_mem[2]  = v.l1;
      coef_mem[3]  = v.b1;
      exp_sc[0]    = v.s0;
      exp_sc[1]    = v.s1;
      exp_win      = v.win;
   endtask

   initial begin
      vt[0] = '{16'sh2000, 16'sh0000, 16'sh4000, 16'shF000, 16'sh0000, 16'sh0000, 1, 64'sd8192,   64'sd12288};
      vt[1] = '{16'sh2000, 16'sh0000, 16'sh2000, 16'sh0000, 16'sh0000, 16'sh0000, 0, 64'sd8192,   64'sd8192};
      vt[2] = '{16'sh4000, 16'sh0000, 16'sh0000, 16'sh4000, 16'sh4000, 16'sh4000, 0, 64'sh20000, 64'sd16384};

      reset     = 1'b0;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      clear_mems();
      repeat (3) @(negedge clk);
      check_idle(0, "rst_a");
      check_idle(1, "rst_b");
      reset = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 3; k++) begin
         load_vec(vt[k]);
         run_and_check(0, 0, $sformatf("vec%0d", k));
      end

      load_vec(vt[0]);
      mon_en = 1'b1;
      run_and_check(0, 1, "proto");
      mon_en = 1'b0;
      chk("proto_img_reads", img_cnt, 1568);
      chk("proto_img_seq_bad", img_bad, 0);
      chk("proto_sv_reads", sv_cnt, 1568);
      chk("proto_sv_seq_bad", sv_bad, 0);
      chk("proto_coef_reads", cf_cnt, 4);
      for (int k = 0; k < 4; k++) chk($sformatf("proto_coef%0d", k), cf_log[k], k);
      repeat (3) @(negedge clk);
      chk("proto_idle_after", ifa.ready, 1);

      // Abort mid-DOT, then a fresh full pass
      @(negedge clk); ifa.start = 1'b1;
      @(negedge clk); ifa.start = 1'b0;
      repeat (300) @(negedge clk);
      chk("abort_pre_img_en", ifa.img_en, 1);
      #2 reset = 1'b0;
      #1 check_idle(0, "abort");
      @(negedge clk);
      reset = 1'b1;
      run_and_check(0, 0, "after_abort");

      for (int r = 0; r < 4; r++) begin
         fill_random(r);
         ref_model(B_NC, B_SPC);
         run_and_check(1, 0, $sformatf("randB%0d", r));
      end
      for (int r = 0; r < 2; r++) begin
         fill_random(r + 1);
         ref_model(A_NC, A_SPC);
         run_and_check(0, 0, $sformatf("randA%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
